// File: rtl/depthconv_weight_writer.sv
// Depthwise-conv weight loader: transposes a channel-major byte stream into
// lane-masked 64-bit weight-buffer writes, one word per kernel tap per part.
module depthconv_weight_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_load,
  input  logic [3:0]  mode,
  input  logic [12:0] addr_start_w,
  input  logic [7:0]  in_piece,
  input  logic [4:0]  part_num,
  input  logic [3:0]  last_part,
  input  logic [3:0]  i_kernel,
  input  logic [7:0]  i_w_data,
  input  logic        i_w_valid,
  output logic        o_w_ready,
  output logic        o_wbuf_we,
  output logic [12:0] o_wbuf_addr,
  output logic [63:0] o_wbuf_wdata,
  output logic [7:0]  o_wbuf_be,
  output logic        o_load_end,
  output logic        o_cfg_err
);

  localparam logic [3:0] DEPTH_CONV_MODE = 4'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  kk_q, kk_d;
  logic [7:0]  pieces_q, pieces_d;
  logic [4:0]  parts_q, parts_d;
  logic [3:0]  last_part_q, last_part_d;
  logic [7:0]  tap_q, tap_d;
  logic [2:0]  lane_q, lane_d;
  logic [4:0]  part_q, part_d;
  logic [7:0]  piece_q, piece_d;
  logic [12:0] part_base_q, part_base_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  be_q, be_d;
  logic        load_end_q, load_end_d;
  logic        cfg_err_q, cfg_err_d;

  logic        cfg_ok;
  logic [7:0]  kk_in;
  logic [3:0]  lp_m1;
  logic [2:0]  lane_lim;
  logic        hs, tap_last, lane_last, part_last, piece_last;

  assign kk_in  = {4'd0, i_kernel} * {4'd0, i_kernel};
  assign cfg_ok = (i_kernel != 4'd0) && (in_piece != 8'd0) && (part_num != 5'd0) &&
                  (last_part != 4'd0) && (last_part <= 4'd8);

  // The final part of each piece only carries last_part lanes.
  assign lp_m1      = last_part_q - 4'd1;
  assign part_last  = (part_q == parts_q - 5'd1);
  assign lane_lim   = part_last ? lp_m1[2:0] : 3'd7;
  assign tap_last   = (tap_q == kk_q - 8'd1);
  assign lane_last  = (lane_q == lane_lim);
  assign piece_last = (piece_q == pieces_q - 8'd1);
  assign hs         = i_w_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    kk_d        = kk_q;
    pieces_d    = pieces_q;
    parts_d     = parts_q;
    last_part_d = last_part_q;
    tap_d       = tap_q;
    lane_d      = lane_q;
    part_d      = part_q;
    piece_d     = piece_q;
    part_base_d = part_base_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    be_d        = be_q;
    load_end_d  = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_load && (mode == DEPTH_CONV_MODE)) begin
          if (cfg_ok) begin
            state_d     = ST_LOAD;
            kk_d        = kk_in;
            pieces_d    = in_piece;
            parts_d     = part_num;
            last_part_d = last_part;
            tap_d       = 8'd0;
            lane_d      = 3'd0;
            part_d      = 5'd0;
            piece_d     = 8'd0;
            part_base_d = addr_start_w;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (hs) begin
          we_d   = 1'b1;
          addr_d = part_base_q + {5'd0, tap_q};
          be_d   = 8'd1 << lane_q;
          data_d = i_w_data;
          if (!tap_last) begin
            tap_d = tap_q + 8'd1;
          end else begin
            tap_d = 8'd0;
            if (!lane_last) begin
              lane_d = lane_q + 3'd1;
            end else begin
              // Pieces sit back to back, so the base never rewinds.
              lane_d      = 3'd0;
              part_base_d = part_base_q + {5'd0, kk_q};
              if (!part_last) begin
                part_d = part_q + 5'd1;
              end else begin
                part_d = 5'd0;
                if (piece_last) begin
                  state_d    = ST_DONE;
                  load_end_d = 1'b1;
                end else begin
                  piece_d = piece_q + 8'd1;
                end
              end
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      kk_q        <= 8'd0;
      pieces_q    <= 8'd0;
      parts_q     <= 5'd0;
      last_part_q <= 4'd0;
      tap_q       <= 8'd0;
      lane_q      <= 3'd0;
      part_q      <= 5'd0;
      piece_q     <= 8'd0;
      part_base_q <= 13'd0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 13'd0;
      data_q      <= 8'd0;
      be_q        <= 8'd0;
      load_end_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kk_q        <= kk_d;
      pieces_q    <= pieces_d;
      parts_q     <= parts_d;
      last_part_q <= last_part_d;
      tap_q       <= tap_d;
      lane_q      <= lane_d;
      part_q      <= part_d;
      piece_q     <= piece_d;
      part_base_q <= part_base_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      be_q        <= be_d;
      load_end_q  <= load_end_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign o_w_ready    = ready_q;
  assign o_wbuf_we    = we_q;
  assign o_wbuf_addr  = addr_q;
  assign o_wbuf_wdata = {8{data_q}};
  assign o_wbuf_be    = be_q;
  assign o_load_end   = load_end_q;
  assign o_cfg_err    = cfg_err_q;

endmodule

// File: doc/depthconv_weight_writer.md
# depthconv_weight_writer

Fills the on-chip weight buffer with depthwise-convolution kernels in exactly the layout the depthwise weight-address generator reads back: one 64-bit word per kernel tap per part, eight 8-bit lanes per word (lane n feeds PE n). It accepts a channel-major weight byte stream from the load path and transposes it into lane-masked buffer writes. When the last word has been written, it reports completion to the scheduler.

## Interface

Parameters:
- none. Buffer address is 13 bits, word is 64 bits, lanes are fixed at 8.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- start_load  in  1  single-cycle start from schedule; honoured only in IDLE with mode == 6 (DEPTH_CONV_MODE)
- mode  in  4  layer mode from decoder
- addr_start_w  in  13  buffer base address of the layer's weights
- in_piece  in  8  number of channel pieces; legal range 1..255
- part_num  in  5  parts per piece; legal range 1..31
- last_part  in  4  valid lanes in the final part of each piece; legal range 1..8
- i_kernel  in  4  kernel side k; legal range 1..15
- i_w_data  in  8  weight byte
- i_w_valid  in  1  weight byte present
- o_w_ready  out  1  byte accepted when i_w_valid && o_w_ready
- o_wbuf_we  out  1  buffer write strobe
- o_wbuf_addr  out  13  buffer write address
- o_wbuf_wdata  out  64  i_w_data replicated into all 8 lanes; lane 0 = bits [7:0]
- o_wbuf_be  out  8  one-hot lane byte-enable
- o_load_end  out  1  one-cycle completion pulse
- o_cfg_err  out  1  one-cycle pulse when a start is rejected

## Operation

- States:
  - IDLE: o_w_ready = 0.
  - LOAD: o_w_ready = 1.
  - DONE: lasts one cycle, then returns to IDLE.
- IDLE -> LOAD on start_load && mode == 6 && config legal. On this transition, capture all configuration inputs and clear the counters:
  - tap = 0, lane = 0, part = 0, piece = 0
  - part_base = addr_start_w
- Illegal config at start: any of i_kernel, in_piece, part_num, last_part equal to 0, or last_part > 8.
  - o_cfg_err pulses in the next cycle.
  - The state remains IDLE and no writes occur.
- start_load in LOAD or DONE is ignored. Configuration inputs are not sampled after capture.
- Stream order, outermost to innermost: piece, part, lane, tap (tap = ky*k + kx, row-major).
- Lanes per part = 8, except the final part of each piece, which has last_part lanes.
- Each accepted byte produces one write:
  - addr = part_base + tap
  - be = 1 << lane
  - wdata = {8{byte}}
- Counter advance on each accepted byte:
  - tap wraps at k*k - 1, then increments lane.
  - lane wraps at the lane count, then increments part and advances part_base by k*k.
  - part wraps at part_num - 1, then increments piece. part_base keeps advancing, so pieces are contiguous.
- The final byte is the one at last tap, last lane, last part, last piece. It moves the state LOAD -> DONE.
- Total bytes per layer = in_piece * ((part_num - 1)*8 + last_part) * k*k.
- Arithmetic:
  - k*k is held as 8 bits (maximum 225).
  - Address sums are 13 bits and wrap modulo 8192. Writes past 8191 wrap to 0 without an error.
- Lanes beyond last_part in the final part are never written; they keep their previous contents.

## Timing

- Reset values: state IDLE, o_w_ready 0, o_wbuf_we 0, o_wbuf_addr 0, o_wbuf_wdata 0, o_wbuf_be 0, o_load_end 0, o_cfg_err 0, all counters 0.
- o_w_ready is a registered state decode. It goes high in the cycle after start_load is accepted.
- Write outputs are registered:
  - A byte accepted at edge t appears with o_wbuf_we = 1 in cycle t+1.
  - o_wbuf_we is 0 in any cycle following a cycle with no handshake.
  - Full throughput: one byte per cycle when i_w_valid is held high.
- o_load_end is high exactly in the cycle the final write is presented (the DONE cycle). A reader may start on the following cycle.
- o_w_ready drops in the DONE cycle. Bytes offered then are not accepted.
- Asynchronous reset mid-load:
  - All outputs return to their reset values immediately.
  - A pending registered write is discarded.
  - A new start_load is required.

## Test plan

- Start with k=3, in_piece=1, part_num=1, last_part=8, addr_start_w=100; stream 72 bytes with valid held high -> 72 consecutive writes. Bytes 0..8 go to addr 100..108 with be=0x01; bytes 9..17 go to 100..108 with be=0x02; and so on to be=0x80. o_load_end coincides with the 72nd write. o_w_ready is 0 afterwards.
- k=3, in_piece=2, part_num=2, last_part=3 -> 198 writes. Piece 0 part 0 uses addr 0..8 with lanes 0..7. Piece 0 part 1 uses addr 9..17 with lanes 0..2 only. Piece 1 part 0 starts at addr 18.
- k=1, in_piece=1, part_num=1, last_part=1; valid toggles every other cycle -> exactly 1 write at addr_start_w with be=0x01. o_load_end pulses once.
- Start with last_part=0, then again with i_kernel=0 -> o_cfg_err pulses one cycle after each start. No writes occur and o_w_ready stays 0.
- addr_start_w=8190, k=2, last_part=1 -> writes go to addr 8190, 8191, 0, 1.
- Assert rst low after 10 bytes of a 72-byte load -> o_wbuf_we and o_w_ready are 0 immediately. A subsequent start restarts at addr_start_w, lane 0.
